// File: rtl/ppe_ifmap_fetch.sv
`default_nettype none
// ==========================================================================
// ppe_ifmap_fetch : PPE-side ifmap row FIFO and IFMAP-memory request initiator
// Rev 1.0
// ==========================================================================
module ppe_ifmap_fetch #(
   parameter int PE_ID        = 5,
   parameter int IMEM_ID      = 10,
   parameter int IFMAP_SIZE   = 25,
   parameter int ROWS_PER_TS  = 5,
   parameter int DEPTH        = 2,
   parameter int OP_PPE_INPUT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IFMAP_SIZE+7:0] pkt_in,
   input  logic                  pkt_in_valid,
   output logic                  pkt_in_ready,
   output logic [IFMAP_SIZE+7:0] pkt_out,
   output logic                  pkt_out_valid,
   input  logic                  pkt_out_ready,
   output logic [IFMAP_SIZE-1:0] row_data,
   output logic [4:0]            row_num,
   output logic                  row_valid,
   input  logic                  row_ready,
   output logic [1:0]            timestep,
   output logic                  ts_done,
   input  logic                  next_ts,
   output logic                  all_done,
   output logic                  drop_err
);

   localparam int PKT_W = IFMAP_SIZE + 8;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(ROWS_PER_TS + 1);

   localparam logic [AW:0]       DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]       OCC_ONE = (AW+1)'(1);
   localparam logic [CNT_W-1:0]  ROWS_C  = CNT_W'(ROWS_PER_TS);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [PKT_W-1:0]  REQ_PKT = {4'(IMEM_ID), 4'(PE_ID), {IFMAP_SIZE{1'b0}}};

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      STREAM     = 2'd1,
      DRAIN      = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t                 state;
   logic [IFMAP_SIZE-1:0]  data_mem [DEPTH];
   logic [4:0]             num_mem  [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            occ;
   logic [CNT_W-1:0]       rows_rcvd;
   logic [CNT_W-1:0]       rows_used;
   logic                   req_pending;

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic                   last_row_push;
   logic [CNT_W-1:0]       used_next;
   logic [4:0]             push_num;

   function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign pkt_in_ready  = (occ < DEPTH_C);
   assign accept        = pkt_in_valid && pkt_in_ready;
   assign push          = accept
                       && (pkt_in[PKT_W-1 -: 4] == 4'(PE_ID))
                       && (pkt_in[PKT_W-5 -: 4] == 4'(OP_PPE_INPUT))
                       && (rows_rcvd < ROWS_C)
                       && (state != DONE);
   assign row_valid     = (occ != '0);
   assign pop           = row_valid && row_ready;
   assign row_data      = data_mem[rd_ptr];
   assign row_num       = num_mem[rd_ptr];
   assign last_row_push = push && ((rows_rcvd + CNT_ONE) == ROWS_C);
   assign used_next     = pop ? (rows_used + CNT_ONE) : rows_used;
   // Row k of this PE is ifmap row (PE_ID-5)+5k
   assign push_num      = 5'(PE_ID - 5) + (5'(rows_rcvd) * 5'd5);
   assign issue         = (state == STREAM) && !req_pending && !pkt_out_valid
                       && (rows_rcvd < ROWS_C) && pkt_in_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= pkt_in[IFMAP_SIZE-1:0];
         num_mem[wr_ptr]  <= push_num;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= WAIT_FIRST;
         timestep      <= 2'd1;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         occ           <= '0;
         rows_rcvd     <= '0;
         rows_used     <= '0;
         req_pending   <= 1'b0;
         pkt_out_valid <= 1'b0;
         pkt_out       <= '0;
         ts_done       <= 1'b0;
         all_done      <= 1'b0;
         drop_err      <= 1'b0;
      end else begin
         drop_err  <= accept && !push;
         rows_used <= used_next;

         if (push) begin
            wr_ptr      <= inc_ptr(wr_ptr);
            rows_rcvd   <= rows_rcvd + CNT_ONE;
            req_pending <= 1'b0;
         end
         if (pop) begin
            rd_ptr <= inc_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase

         // Only one request may be in flight; the returning row clears it
         if (issue) begin
            pkt_out_valid <= 1'b1;
            pkt_out       <= REQ_PKT;
         end else if (pkt_out_valid && pkt_out_ready) begin
            pkt_out_valid <= 1'b0;
            req_pending   <= 1'b1;
         end

         case (state)
            WAIT_FIRST: begin
               if (push) begin
                  state <= last_row_push ? DRAIN : STREAM;
               end
            end
            STREAM: begin
               if (last_row_push) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (used_next == ROWS_C) begin
                  state   <= DONE;
                  ts_done <= 1'b1;
               end
            end
            DONE: begin
               if (next_ts) begin
                  if (timestep == 2'd1) begin
                     timestep    <= 2'd2;
                     rows_rcvd   <= '0;
                     rows_used   <= '0;
                     req_pending <= 1'b0;
                     ts_done     <= 1'b0;
                     state       <= WAIT_FIRST;
                  end else begin
                     all_done <= 1'b1;
                  end
               end
            end
            default: state <= WAIT_FIRST;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ppe_ifmap_fetch.sv
`default_nettype none
// Randomised directed bench for ppe_ifmap_fetch against a queue-based row/request model.
module tb_ppe_ifmap_fetch;

   localparam int PE_ID   = 5;
   localparam int IMEM_ID = 10;
   localparam int ROWS    = 5;
   localparam int DEPTH   = 2;
   localparam int OP_IN   = 1;
   localparam logic [32:0] REQ = {4'(IMEM_ID), 4'(PE_ID), 25'h0};

   logic        clk = 1'b0;
   logic        reset;
   logic [32:0] pkt_in;
   logic        pkt_in_valid;
   logic        pkt_in_ready;
   logic [32:0] pkt_out;
   logic        pkt_out_valid;
   logic        pkt_out_ready;
   logic [24:0] row_data;
   logic [4:0]  row_num;
   logic        row_valid;
   logic        row_ready;
   logic [1:0]  timestep;
   logic        ts_done;
   logic        next_ts;
   logic        all_done;
   logic        drop_err;

   ppe_ifmap_fetch dut (
      .clk(clk), .reset(reset),
      .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
      .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
      .row_data(row_data), .row_num(row_num), .row_valid(row_valid), .row_ready(row_ready),
      .timestep(timestep), .ts_done(ts_done), .next_ts(next_ts),
      .all_done(all_done), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [29:0] mq[$];
   int  m_rcvd, m_used, m_ts, d_reqs;
   bit  m_out, exp_pv, m_tsdone, m_all;
   bit  rand_mode, last_acc;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] exp_num(input int k);
      return 5'((PE_ID - 5) + 5 * k);
   endfunction

   task automatic model_clear();
      mq.delete();
      m_rcvd = 0; m_used = 0; m_ts = 1; d_reqs = 0;
      m_out = 0; exp_pv = 0; m_tsdone = 0; m_all = 0;
   endtask

   task automatic cycle();
      bit acc, good, pop, hs, issue, nts;
      logic [32:0] p;
      if (rand_mode) begin
         row_ready     = 1'($urandom_range(0, 1));
         pkt_out_ready = 1'($urandom_range(0, 1));
      end
      p     = pkt_in;
      acc   = pkt_in_valid && (mq.size() < DEPTH);
      good  = acc && (p[32:29] == 4'(PE_ID)) && (p[28:25] == 4'(OP_IN)) && (m_rcvd < ROWS);
      pop   = row_ready && (mq.size() > 0);
      hs    = exp_pv && pkt_out_ready;
      issue = (m_rcvd >= 1) && (m_rcvd < ROWS) && !m_out && !exp_pv && (mq.size() < DEPTH);
      nts   = next_ts;
      if (pkt_out_valid && pkt_out_ready) d_reqs++;
      @(posedge clk); #1;
      if (pop) begin
         void'(mq.pop_front());
         m_used++;
      end
      if (good) begin
         mq.push_back({p[24:0], exp_num(m_rcvd)});
         m_rcvd++;
         m_out = 0;
      end
      if (hs) m_out = 1;
      exp_pv = issue ? 1'b1 : (exp_pv && !hs);
      if (nts && m_tsdone) begin
         if (m_ts == 1) begin
            m_ts = 2; m_rcvd = 0; m_used = 0; m_out = 0; m_tsdone = 0;
         end else begin
            m_all = 1;
         end
      end else if (!m_tsdone && m_used == ROWS) begin
         m_tsdone = 1;
      end
      last_acc = acc;
      chk("row_valid", row_valid, 33'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("row_data", row_data, 33'(mq[0][29:5]));
         chk("row_num", row_num, 33'(mq[0][4:0]));
      end
      chk("pkt_in_ready", pkt_in_ready, 33'(mq.size() < DEPTH));
      chk("drop_err", drop_err, 33'(acc && !good));
      chk("pkt_out_valid", pkt_out_valid, 33'(exp_pv));
      if (exp_pv) chk("pkt_out", pkt_out, REQ);
      chk("timestep", timestep, 33'(m_ts));
      chk("ts_done", ts_done, 33'(m_tsdone));
      chk("all_done", all_done, 33'(m_all));
   endtask

   task automatic send_pkt(input logic [24:0] d, input int dest, input int op);
      pkt_in       = {4'(dest), 4'(op), d};
      pkt_in_valid = 1'b1;
      last_acc     = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (last_acc) break;
      end
      if (!last_acc) chk("accept_timeout", 33'(last_acc), 33'd1);
      pkt_in_valid = 1'b0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 300; i++) begin
         if (m_out) break;
         cycle();
      end
      if (!m_out) chk("request_timeout", 33'(m_out), 33'd1);
   endtask

   task automatic finish_ts();
      while (m_rcvd < ROWS) begin
         if (m_rcvd > 0) wait_req();
         send_pkt(25'($urandom), PE_ID, OP_IN);
         if (!last_acc) break;
      end
   endtask

   task automatic wait_tsdone();
      rand_mode = 0;
      row_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (m_tsdone) break;
         cycle();
      end
      chk("ts_done_reached", ts_done, 33'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; pkt_in = '0; pkt_in_valid = 1'b0; pkt_out_ready = 1'b0;
      row_ready = 1'b0; next_ts = 1'b0; rand_mode = 0; last_acc = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pkt_out_valid", pkt_out_valid, 33'd0);
      chk("rst_pkt_out", pkt_out, 33'd0);
      chk("rst_row_valid", row_valid, 33'd0);
      chk("rst_pkt_in_ready", pkt_in_ready, 33'd1);
      chk("rst_timestep", timestep, 33'd1);
      chk("rst_ts_done", ts_done, 33'd0);
      chk("rst_all_done", all_done, 33'd0);
      chk("rst_drop_err", drop_err, 33'd0);
      reset = 1'b0;
      cycle();

      // unsolicited first row, then the request appears and is held
      send_pkt(25'h1ABCDEF, PE_ID, OP_IN);
      chk("t1_row_num", row_num, 33'd0);
      chk("t1_row_data", row_data, 33'h1ABCDEF);
      cycle();
      chk("t1_req_valid", pkt_out_valid, 33'd1);
      chk("t1_req_pkt", pkt_out, REQ);
      repeat (6) cycle();
      pkt_out_ready = 1'b1;
      cycle();
      repeat (4) cycle();
      chk("t2_no_second_req", pkt_out_valid, 33'd0);

      next_ts = 1'b1;
      cycle();
      next_ts = 1'b0;
      chk("next_ts_ignored", timestep, 33'd1);

      // FIFO full blocks both input and requests until a pop
      send_pkt(25'($urandom), PE_ID, OP_IN);
      chk("t4_full_ready", pkt_in_ready, 33'd0);
      repeat (4) cycle();
      chk("t4_no_req_full", pkt_out_valid, 33'd0);
      row_ready = 1'b1;
      cycle();
      row_ready = 1'b0;
      chk("t4_ready_after_pop", pkt_in_ready, 33'd1);
      cycle();
      chk("t4_req_reissued", pkt_out_valid, 33'd1);

      send_pkt(25'($urandom), 6, OP_IN);
      chk("drop_dest", drop_err, 33'd1);
      send_pkt(25'($urandom), PE_ID, 0);
      chk("drop_opcode", drop_err, 33'd1);

      rand_mode = 1;
      finish_ts();
      send_pkt(25'($urandom), PE_ID, OP_IN);
      chk("drop_sixth_row", drop_err, 33'd1);
      wait_tsdone();
      repeat (3) cycle();
      chk("ts1_request_count", 33'(d_reqs), 33'd4);
      chk("ts1_no_late_req", pkt_out_valid, 33'd0);

      next_ts = 1'b1;
      cycle();
      next_ts = 1'b0;
      chk("ts2_timestep", timestep, 33'd2);
      chk("ts2_ts_done_clear", ts_done, 33'd0);
      d_reqs = 0;

      rand_mode = 1;
      finish_ts();
      wait_tsdone();
      repeat (2) cycle();
      chk("ts2_request_count", 33'(d_reqs), 33'd4);
      next_ts = 1'b1;
      cycle();
      next_ts = 1'b0;
      repeat (3) cycle();
      chk("all_done_sticky", all_done, 33'd1);
      send_pkt(25'($urandom), PE_ID, OP_IN);
      chk("drop_in_done", drop_err, 33'd1);

      // reset from DONE, then run into DRAIN and reset again mid-drain
      #2 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      cycle();
      chk("reset2_all_done", all_done, 33'd0);
      rand_mode = 1;
      finish_ts();
      rand_mode = 0;
      row_ready = 1'b0;
      pkt_out_ready = 1'b0;
      cycle();
      chk("pre_reset_row_valid", row_valid, 33'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_reset_row_valid", row_valid, 33'd0);
      chk("mid_reset_timestep", timestep, 33'd1);
      chk("mid_reset_pkt_out_valid", pkt_out_valid, 33'd0);
      chk("mid_reset_pkt_in_ready", pkt_in_ready, 33'd1);
      chk("mid_reset_ts_done", ts_done, 33'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      repeat (2) cycle();
      send_pkt(25'h0123456, PE_ID, OP_IN);
      chk("post_reset_row_num", row_num, 33'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
